// File: rtl/jh_adc_vpp_meas_if.sv
// rtl/jh_adc_vpp_meas_if.sv - SRAM mirror bus and result handshake bundle for jh_adc_vpp_meas
interface jh_adc_vpp_meas_if #(
  parameter int ADC_W      = 14,
  parameter int SRAM_W     = 16,
  parameter int DEPTH_LOG2 = 7
);
  logic [SRAM_W-1:0]     sram_writedata;
  logic [DEPTH_LOG2-1:0] sram_address;
  logic                  sram_write;
  logic [ADC_W-1:0]      Vpp;
  logic [ADC_W-1:0]      min_last;
  logic [ADC_W-1:0]      max_last;
  logic                  result_valid;
  logic                  result_ack;
  logic                  busy;
  logic                  abort;

  modport master (
    output sram_writedata, sram_address, sram_write,
    output Vpp, min_last, max_last, result_valid, busy, abort,
    input  result_ack
  );

  modport slave (
    input  sram_writedata, sram_address, sram_write,
    input  Vpp, min_last, max_last, result_valid, busy, abort,
    output result_ack
  );
endinterface

// File: rtl/jh_adc_vpp_meas.sv
// rtl/jh_adc_vpp_meas.sv - burst ADC capture with SRAM mirror, slew-limited min/max and averaged Vpp
module jh_adc_vpp_meas #(
  parameter int ADC_W         = 14,
  parameter int SRAM_W        = 16,
  parameter int DEPTH_LOG2    = 7,
  parameter int SETTLE_CYCLES = 65535,
  parameter int GLITCH_TH     = 64,
  parameter int AVG_LOG2      = 0
) (
  input  logic             CLOCK_65,
  input  logic             rst,
  input  logic             start_write,
  input  logic [ADC_W-1:0] monitor_ADC,
  jh_adc_vpp_meas_if.master bus
);

  localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SUM_W   = ADC_W + AVG_LOG2;
  localparam int BURST_W = AVG_LOG2 + 1;
  localparam int CMP_W   = ADC_W + 1;

  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_LAST  = BURST_W'((1 << AVG_LOG2) - 1);
  localparam logic [CMP_W-1:0]   TH          = CMP_W'(GLITCH_TH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_ACCUM,
    S_DONE,
    S_WAIT_OFF
  } state_t;

  state_t state, state_nxt;

  logic [SET_W-1:0]      settle_cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [BURST_W-1:0]    burst_cnt_q;
  logic [SUM_W-1:0]      sum_q;
  logic [ADC_W-1:0]      min_q, max_q;

  logic [SRAM_W-1:0]     sram_writedata_q;
  logic [DEPTH_LOG2-1:0] sram_address_q;
  logic                  sram_write_q;
  logic [ADC_W-1:0]      vpp_q, min_last_q, max_last_q;
  logic                  result_valid_q, busy_q, abort_q;

  logic do_abort;
  logic settle_done, idx_last, burst_last;
  logic take_max, take_min;

  logic [CMP_W-1:0] s_x, max_x, min_x;

  assign settle_done = (settle_cnt_q == SETTLE_LAST);
  assign idx_last    = &idx_q;
  assign burst_last  = (burst_cnt_q == BURST_LAST);

  // One extra bit so adding the threshold to a near-full-scale code cannot wrap
  assign s_x   = {1'b0, monitor_ADC};
  assign max_x = {1'b0, max_q};
  assign min_x = {1'b0, min_q};

  // Slew limiter: accept a new extreme only if it moved by at most GLITCH_TH
  always_comb begin
    take_max = 1'b0;
    take_min = 1'b0;
    if (s_x > max_x) take_max = (GLITCH_TH == 0) || (s_x <= max_x + TH);
    if (s_x < min_x) take_min = (GLITCH_TH == 0) || (s_x + TH >= min_x);
  end

  // State register
  always_ff @(posedge CLOCK_65) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; dropping start_write mid-measurement aborts to IDLE
  always_comb begin
    state_nxt = state;
    do_abort  = 1'b0;
    case (state)
      S_IDLE:     if (start_write) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (!start_write) begin
          do_abort  = 1'b1;
          state_nxt = S_IDLE;
        end else if (settle_done) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!start_write) begin
          do_abort  = 1'b1;
          state_nxt = S_IDLE;
        end else if (idx_last) begin
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!start_write) begin
          do_abort  = 1'b1;
          state_nxt = S_IDLE;
        end else if (burst_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_CAPTURE;
        end
      end
      S_DONE:     state_nxt = S_WAIT_OFF;
      S_WAIT_OFF: if (!start_write) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, advanced on the same edge as the state
  always_ff @(posedge CLOCK_65) begin
    if (rst) begin
      settle_cnt_q     <= '0;
      idx_q            <= '0;
      burst_cnt_q      <= '0;
      sum_q            <= '0;
      min_q            <= '0;
      max_q            <= '0;
      sram_writedata_q <= '0;
      sram_address_q   <= '0;
      sram_write_q     <= 1'b0;
      vpp_q            <= '0;
      min_last_q       <= '0;
      max_last_q       <= '0;
      result_valid_q   <= 1'b0;
      busy_q           <= 1'b0;
      abort_q          <= 1'b0;
    end else begin
      abort_q      <= do_abort;
      sram_write_q <= 1'b0;
      if (result_valid_q && bus.result_ack) result_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_write) begin
            settle_cnt_q   <= '0;
            burst_cnt_q    <= '0;
            sum_q          <= '0;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (do_abort) begin
            busy_q <= 1'b0;
          end else begin
            settle_cnt_q   <= settle_cnt_q + SET_W'(1);
            idx_q          <= '0;
            sram_address_q <= '0;
          end
        end
        S_CAPTURE: begin
          if (do_abort) begin
            busy_q <= 1'b0;
          end else begin
            sram_write_q     <= 1'b1;
            sram_writedata_q <= SRAM_W'(monitor_ADC);
            sram_address_q   <= idx_q;
            idx_q            <= idx_q + DEPTH_LOG2'(1);
            if (idx_q == '0) begin
              min_q <= monitor_ADC;
              max_q <= monitor_ADC;
            end else begin
              if (take_max) max_q <= monitor_ADC;
              if (take_min) min_q <= monitor_ADC;
            end
          end
        end
        S_ACCUM: begin
          if (do_abort) begin
            busy_q <= 1'b0;
          end else begin
            sum_q          <= sum_q + SUM_W'(max_q - min_q);
            min_last_q     <= min_q;
            max_last_q     <= max_q;
            burst_cnt_q    <= burst_cnt_q + BURST_W'(1);
            sram_address_q <= '0;
          end
        end
        S_DONE: begin
          vpp_q          <= ADC_W'(sum_q >> AVG_LOG2);
          result_valid_q <= 1'b1;
          busy_q         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sram_writedata = sram_writedata_q;
  assign bus.sram_address   = sram_address_q;
  assign bus.sram_write     = sram_write_q;
  assign bus.Vpp            = vpp_q;
  assign bus.min_last       = min_last_q;
  assign bus.max_last       = max_last_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.busy           = busy_q;
  assign bus.abort          = abort_q;

endmodule

// File: tb/tb_jh_adc_vpp_meas.sv
// tb/tb_jh_adc_vpp_meas.sv - self-checking bench for jh_adc_vpp_meas
module tb_jh_adc_vpp_meas;
  localparam int ADC_W         = 14;
  localparam int SRAM_W        = 16;
  localparam int DEPTH_LOG2    = 3;
  localparam int DEPTH         = 8;
  localparam int SETTLE_CYCLES = 4;
  localparam int GLITCH_TH     = 64;
  localparam int AVG_LOG2      = 2;
  localparam int NBURST        = 4;

  logic             CLOCK_65 = 1'b0;
  logic             rst;
  logic             start_write;
  logic [ADC_W-1:0] monitor_ADC;

  jh_adc_vpp_meas_if #(.ADC_W(ADC_W), .SRAM_W(SRAM_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  jh_adc_vpp_meas #(
    .ADC_W(ADC_W), .SRAM_W(SRAM_W), .DEPTH_LOG2(DEPTH_LOG2),
    .SETTLE_CYCLES(SETTLE_CYCLES), .GLITCH_TH(GLITCH_TH), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .CLOCK_65(CLOCK_65),
    .rst(rst),
    .start_write(start_write),
    .monitor_ADC(monitor_ADC),
    .bus(bus)
  );

  always #8 CLOCK_65 = ~CLOCK_65;

  int n_pass  = 0;
  int n_total = 0;
  int samp [DEPTH];
  int exp_vpp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_65);
    @(negedge CLOCK_65);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wdata"}, 32'(bus.sram_writedata), 0);
    check({tag, "_addr"},  32'(bus.sram_address), 0);
    check({tag, "_write"}, 32'(bus.sram_write), 0);
    check({tag, "_vpp"},   32'(bus.Vpp), 0);
    check({tag, "_min"},   32'(bus.min_last), 0);
    check({tag, "_max"},   32'(bus.max_last), 0);
    check({tag, "_valid"}, 32'(bus.result_valid), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_abort"}, 32'(bus.abort), 0);
  endtask

  // Reference: seed with the first sample, then accept only bounded moves outward
  task automatic model_burst(output int mn, output int mx);
    mn = samp[0];
    mx = samp[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (samp[i] > mx && (samp[i] - mx) <= GLITCH_TH) mx = samp[i];
      if (samp[i] < mn && (mn - samp[i]) <= GLITCH_TH) mn = samp[i];
    end
  endtask

  // mode 0 ramp, 1 glitch burst first, 2 fixed Vpp per burst, 3 random walk with spikes
  task automatic gen_burst(input int mode, input int b);
    int glitch [DEPTH] = '{1000, 1010, 5000, 990, 1020, 1015, 1005, 995};
    int vtab [NBURST] = '{100, 104, 96, 101};
    int nom;
    case (mode)
      1: for (int i = 0; i < DEPTH; i++) samp[i] = (b == 0) ? glitch[i] : 100 + 10 * i;
      2: for (int i = 0; i < DEPTH; i++) samp[i] = 2000 + ((50 * i < vtab[b]) ? 50 * i : vtab[b]);
      3: begin
        nom = int'($urandom_range(2000, 14000));
        for (int i = 0; i < DEPTH; i++) begin
          if ($urandom_range(0, 5) == 0) begin
            samp[i] = ($urandom_range(0, 1) == 1) ? nom + 1500 : nom - 1500;
          end else begin
            nom = nom + int'($urandom_range(0, 120)) - 60;
            samp[i] = nom;
          end
        end
      end
      default: for (int i = 0; i < DEPTH; i++) samp[i] = 100 + 10 * i;
    endcase
  endtask

  task automatic accept_and_settle();
    start_write = 1'b1;
    monitor_ADC = ADC_W'($urandom_range(0, 16383));
    tick();
    check("accept_busy", 32'(bus.busy), 1);
    check("accept_valid_clr", 32'(bus.result_valid), 0);
    for (int k = 0; k < SETTLE_CYCLES; k++) begin
      monitor_ADC = ADC_W'($urandom_range(0, 16383));
      tick();
      check("settle_no_write", 32'(bus.sram_write), 0);
    end
  endtask

  task automatic capture_sample(input int i);
    monitor_ADC = ADC_W'(samp[i]);
    tick();
    check("cap_write", 32'(bus.sram_write), 1);
    check("cap_addr", 32'(bus.sram_address), i);
    check("cap_data", 32'(bus.sram_writedata), samp[i]);
  endtask

  task automatic run_measure(input int mode);
    int mn, mx, sum;
    sum = 0;
    accept_and_settle();
    for (int b = 0; b < NBURST; b++) begin
      gen_burst(mode, b);
      for (int i = 0; i < DEPTH; i++) capture_sample(i);
      monitor_ADC = ADC_W'($urandom_range(0, 16383));
      tick();
      model_burst(mn, mx);
      sum += mx - mn;
      check("accum_write_off", 32'(bus.sram_write), 0);
      check("burst_min", 32'(bus.min_last), mn);
      check("burst_max", 32'(bus.max_last), mx);
      check("valid_not_early", 32'(bus.result_valid), 0);
    end
    tick();
    exp_vpp = sum / NBURST;
    check("done_valid", 32'(bus.result_valid), 1);
    check("done_vpp", 32'(bus.Vpp), exp_vpp);
    check("done_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    rst         = 1'b1;
    start_write = 1'b0;
    monitor_ADC = '0;
    bus.result_ack = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_no_write", 32'(bus.sram_write), 0);

    run_measure(0);

    for (int k = 0; k < 50; k++) begin
      tick();
      check("waitoff_write", 32'(bus.sram_write), 0);
      check("waitoff_busy", 32'(bus.busy), 0);
    end
    check("waitoff_valid_held", 32'(bus.result_valid), 1);
    start_write = 1'b0;
    tick();
    check("idle_valid_held", 32'(bus.result_valid), 1);

    run_measure(1);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("ack_clears_valid", 32'(bus.result_valid), 0);
    check("ack_vpp_held", 32'(bus.Vpp), exp_vpp);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("ack_idle_ignored", 32'(bus.result_valid), 0);

    for (int r = 0; r < 3; r++) begin
      start_write = 1'b0;
      tick();
      run_measure(3);
    end

    start_write = 1'b0;
    tick();
    run_measure(2);

    start_write = 1'b0;
    tick();
    start_write = 1'b1;
    tick();
    check("abort_s_accept_clr", 32'(bus.result_valid), 0);
    tick();
    tick();
    start_write = 1'b0;
    tick();
    check("abort_s_pulse", 32'(bus.abort), 1);
    check("abort_s_busy", 32'(bus.busy), 0);
    check("abort_s_write", 32'(bus.sram_write), 0);
    check("abort_s_vpp", 32'(bus.Vpp), exp_vpp);
    check("abort_s_valid", 32'(bus.result_valid), 0);
    tick();
    check("abort_s_one_cycle", 32'(bus.abort), 0);

    accept_and_settle();
    gen_burst(3, 0);
    for (int i = 0; i < 3; i++) capture_sample(i);
    start_write = 1'b0;
    tick();
    check("abort_c_pulse", 32'(bus.abort), 1);
    check("abort_c_write", 32'(bus.sram_write), 0);
    check("abort_c_busy", 32'(bus.busy), 0);
    check("abort_c_vpp", 32'(bus.Vpp), exp_vpp);
    check("abort_c_valid", 32'(bus.result_valid), 0);
    tick();
    check("abort_c_one_cycle", 32'(bus.abort), 0);
    check("abort_c_no_write", 32'(bus.sram_write), 0);

    accept_and_settle();
    gen_burst(0, 0);
    for (int i = 0; i < 5; i++) capture_sample(i);
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    start_write = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_reset_no_write", 32'(bus.sram_write), 0);
    end
    check("post_reset_busy", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
